// File: rtl/gb_pkg.sv
// gb_pkg -- shared definitions for the GB frame controller.
// Holds the controller state encoding and the default stencil/counter sizes
// so that wrappers and checkers elaborate against the same values.
package gb_pkg;
  localparam int GB_K      = 9;   // stencil edge (K x K window)
  localparam int GB_W_BITS = 10;  // column/row counter width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } gb_state_e;
endpackage

// File: rtl/gb_out_reg.sv
// gb_out_reg -- one-entry output holding register with valid/ready.
// Ports:
//   clk, rst    clock, async active-high reset
//   load        capture a new output this cycle (sets valid)
//   load_last   last-of-frame flag travelling with the loaded output
//   out_ready   downstream ready
//   valid, last held output valid and last flag
// A load wins over a same-cycle handshake, which is what lets the stream
// run at one output per cycle.
module gb_out_reg (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic load_last,
  input  logic out_ready,
  output logic valid,
  output logic last
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      last  <= load_last;
    end else if (valid && out_ready) begin
      valid <= 1'b0;
      last  <= 1'b0;
    end
  end
endmodule

// File: rtl/gb_frame_ctrl.sv
// gb_frame_ctrl -- frame sequencer for a K x K stencil stream.
// Tracks the column/row of the next accepted pixel, gates upstream flow on
// downstream back-pressure, and emits one output per fully-covered window.
// Ports:
//   clk, rst                  clock, async active-high reset
//   start, cfg_width/height   frame request and size (sampled on accepted start)
//   in_valid / in_ready       upstream pixel handshake
//   dp_shift                  advance datapath one pixel (= accepted pixel)
//   out_valid/out_ready/last  downstream handshake and end-of-frame marker
//   x_idx, y_idx              position of the next pixel to be accepted
//   busy, done, cfg_err       status: RUN/DRAIN, frame complete, start rejected
// Optional: define GB_FRAME_CTRL_PERF_EN to add perf_stall_in/perf_stall_out
// saturating stall counters.
module gb_frame_ctrl
  import gb_pkg::*;
#(
  parameter int W_BITS = GB_W_BITS,
  parameter int K      = GB_K
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [W_BITS-1:0] cfg_width,
  input  logic [W_BITS-1:0] cfg_height,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              dp_shift,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [W_BITS-1:0] x_idx,
  output logic [W_BITS-1:0] y_idx,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
`ifdef GB_FRAME_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_stall_in,
  output logic [31:0]       perf_stall_out
`endif
);
  localparam logic [W_BITS-1:0] KW  = W_BITS'(K);
  localparam logic [W_BITS-1:0] KM1 = W_BITS'(K - 1);

  gb_state_e         state, state_nxt;
  logic [W_BITS-1:0] width_q, height_q;
  logic              cfg_ok, start_acc, x_end, y_end, emit, last_px, out_hs;

  assign cfg_ok    = (cfg_width >= KW) && (cfg_height >= KW);
  assign start_acc = (state == IDLE) && start && cfg_ok;

  assign in_ready  = (state == RUN) && (!out_valid || out_ready);
  assign dp_shift  = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;

  // Only the latched size is used here so a start ignored mid-frame
  // cannot disturb the running frame.
  assign x_end   = (x_idx == width_q - W_BITS'(1));
  assign y_end   = (y_idx == height_q - W_BITS'(1));
  assign emit    = dp_shift && (x_idx >= KM1) && (y_idx >= KM1);
  assign last_px = dp_shift && x_end && y_end;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE:  if (start_acc) state_nxt = RUN;
      RUN:   if (last_px)   state_nxt = DRAIN;
      DRAIN: if (out_hs) begin
        state_nxt = IDLE;
        done      = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      width_q  <= '0;
      height_q <= '0;
      x_idx    <= '0;
      y_idx    <= '0;
    end else if (start_acc) begin
      width_q  <= cfg_width;
      height_q <= cfg_height;
      x_idx    <= '0;
      y_idx    <= '0;
    end else if (dp_shift) begin
      if (x_end) begin
        x_idx <= '0;
        y_idx <= y_idx + W_BITS'(1);
      end else begin
        x_idx <= x_idx + W_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cfg_err <= 1'b0;
    else     cfg_err <= (state == IDLE) && start && !cfg_ok;
  end

  gb_out_reg u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (emit),
    .load_last (last_px),
    .out_ready (out_ready),
    .valid     (out_valid),
    .last      (out_last)
  );

`ifdef GB_FRAME_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_in  <= '0;
      perf_stall_out <= '0;
    end else if (start_acc) begin
      perf_stall_in  <= '0;
      perf_stall_out <= '0;
    end else begin
      if ((state == RUN) && in_ready && !in_valid && (perf_stall_in != '1))
        perf_stall_in <= perf_stall_in + 32'd1;
      if (out_valid && !out_ready && (perf_stall_out != '1))
        perf_stall_out <= perf_stall_out + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_gb_frame_ctrl.sv
// tb_gb_frame_ctrl -- scoreboard bench for gb_frame_ctrl.
// A tracker turns every accepted pixel into an expected output (last flag and
// the cycle it must appear); a monitor pops and compares as outputs appear.
module tb_gb_frame_ctrl;
  localparam int W  = 10;
  localparam int KK = 9;

  logic         clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic         in_valid = 1'b0, out_ready = 1'b1;
  logic [W-1:0] cfg_width = '0, cfg_height = '0;
  logic         in_ready, dp_shift, out_valid, out_last, busy, done, cfg_err;
  logic [W-1:0] x_idx, y_idx;
`ifdef GB_FRAME_CTRL_PERF_EN
  logic [31:0]  perf_stall_in, perf_stall_out;
`endif

  gb_frame_ctrl #(.W_BITS(W), .K(KK)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .in_valid(in_valid), .in_ready(in_ready), .dp_shift(dp_shift),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .x_idx(x_idx), .y_idx(y_idx), .busy(busy), .done(done), .cfg_err(cfg_err)
`ifdef GB_FRAME_CTRL_PERF_EN
    , .perf_stall_in(perf_stall_in), .perf_stall_out(perf_stall_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic last; int birth; } exp_t;
  exp_t sb[$];

  int cyc = 0;
  int n_chk = 0, n_fail = 0;
  int fw = 9, fh = 9, pcnt = 0;
  int first_acc = 0, last_acc = 0, n_out = 0, done_cnt = 0, done_cyc = 0;
  bit held = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Tracker: a dp_shift seen now is accepted at the next edge, so its window
  // output (if any) must be visible one cycle later.
  initial forever begin
    @(negedge clk);
    if (dp_shift) begin
      if (pcnt == 0) first_acc = cyc;
      if ((pcnt % fw) >= KK - 1 && (pcnt / fw) >= KK - 1)
        sb.push_back('{last: (pcnt == fw * fh - 1), birth: cyc + 1});
      if (pcnt == fw * fh - 1) last_acc = cyc;
      pcnt++;
    end
  end

  // Monitor: a new output is one not still held from a stalled cycle.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      held = 1'b0;
    end else begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (out_valid && !held) begin
        n_out++;
        check("output_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check("out_last", out_last, e.last);
          check("out_birth_cycle", cyc, e.birth);
        end
      end
      held = out_valid && !out_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int w, input int h, input bit track);
    tick();
    cfg_width  = W'(w);
    cfg_height = W'(h);
    start      = 1'b1;
    if (track) begin
      fw = w; fh = h; pcnt = 0;
    end
    tick();
    start = 1'b0;
  endtask

  task automatic wait_pcnt(input int n, input int maxc);
    int k = 0;
    while (pcnt < n && k < maxc) begin
      tick();
      k++;
    end
    check("pixel_progress", pcnt >= n, 1);
  endtask

  task automatic wait_done(input string name, input int maxc);
    int d0 = done_cnt;
    int k = 0;
    while (done_cnt == d0 && k < maxc) begin
      @(negedge clk);
      #1;
      k++;
    end
    check({name, "_done_seen"}, done_cnt > d0, 1);
    if (done_cnt > d0) begin
      check({name, "_done_latency"}, done_cyc - last_acc, 1);
      check({name, "_sb_empty"}, sb.size(), 0);
    end
    tick();
    check({name, "_idle_after"}, busy, 0);
  endtask

  task automatic stall_out(input int n, input bit chk_it);
    out_ready = 1'b0;
    check("stall_entry_valid", out_valid, 1);
    repeat (n) begin
      @(negedge clk);
      if (chk_it) begin
        check("stall_in_ready", in_ready, 0);
        check("stall_dp_shift", dp_shift, 0);
        check("stall_out_valid", out_valid, 1);
      end
      @(posedge clk);
    end
    #1 out_ready = 1'b1;
  endtask

  initial begin
    int o0;
    // reset state
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_x_idx", x_idx, 0);
    check("rst_y_idx", y_idx, 0);
    rst = 1'b0;
    tick();

    // 9x9 full rate: single output, flagged last
    in_valid = 1'b1; out_ready = 1'b1; o0 = n_out;
    start_frame(9, 9, 1);
    check("f9_busy", busy, 1);
    check("f9_x_start", x_idx, 0);
    check("f9_y_start", y_idx, 0);
    wait_done("f9x9", 200);
    check("f9_out_count", n_out - o0, 1);

    // 12x10 full rate: 8 outputs, 120 back-to-back accepts
    o0 = n_out;
    start_frame(12, 10, 1);
    wait_done("f12x10", 300);
    check("f12_out_count", n_out - o0, 8);
    check("f12_throughput", last_acc - first_acc, 119);

    // 12x10 with a 5-cycle downstream stall in the middle of row 8
    o0 = n_out;
    start_frame(12, 10, 1);
    wait_pcnt(12 * 8 + 10, 300);
    stall_out(5, 1);
    wait_done("stall", 300);
    check("stall_out_count", n_out - o0, 8);

    // rejected starts
    in_valid = 1'b0;
    start_frame(8, 9, 0);
    check("err_w8_pulse", cfg_err, 1);
    check("err_w8_busy", busy, 0);
    tick();
    check("err_w8_clear", cfg_err, 0);
    check("err_w8_busy2", busy, 0);
    start_frame(9, 8, 0);
    check("err_h8_pulse", cfg_err, 1);
    check("err_h8_busy", busy, 0);

    // start during RUN must be ignored (frame still completes as 9x9)
    o0 = n_out;
    start_frame(9, 9, 1);
    tick(); tick();
    start_frame(12, 12, 0);
    check("run_start_no_err", cfg_err, 0);
    check("run_start_busy", busy, 1);
    in_valid = 1'b1;
    wait_done("run_start", 200);
    check("run_start_out_count", n_out - o0, 1);

    // reset at pixel 40, then a clean frame
    start_frame(9, 9, 1);
    wait_pcnt(40, 200);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_last", out_last, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_dp_shift", dp_shift, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_x_idx", x_idx, 0);
    check("mid_rst_y_idx", y_idx, 0);
    check("mid_rst_sb_empty", sb.size(), 0);
    tick();
    rst = 1'b0;
    o0 = n_out;
    start_frame(9, 9, 1);
    check("post_rst_busy", busy, 1);
    wait_done("post_rst", 200);
    check("post_rst_out_count", n_out - o0, 1);

`ifdef GB_FRAME_CTRL_PERF_EN
    // 3 idle upstream cycles and 4 blocked downstream cycles
    in_valid = 1'b0; out_ready = 1'b1; o0 = n_out;
    start_frame(12, 10, 1);
    tick(); tick(); tick();
    in_valid = 1'b1;
    wait_pcnt(12 * 8 + 10, 300);
    stall_out(4, 0);
    wait_done("perf", 300);
    check("perf_out_count", n_out - o0, 8);
    check("perf_stall_in", perf_stall_in, 3);
    check("perf_stall_out", perf_stall_out, 4);
`endif

    check("final_sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/gb_frame_ctrl.md
GB_FRAME_CTRL -- requirements
Module: gb_frame_ctrl

Interface
REQ-001 SHALL have parameter W_BITS, default 10: width of the column/row counters and of the frame-size config.
REQ-002 SHALL have parameter K, default 9: stencil edge, so a window is K x K pixels.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  in  1  one-cycle request to begin a frame.
REQ-006 SHALL have port cfg_width  in  W_BITS  frame columns, sampled on an accepted start.
REQ-007 SHALL have port cfg_height  in  W_BITS  frame rows, sampled on an accepted start.
REQ-008 SHALL have port in_valid  in  1  upstream pixel valid (arg_1_TVALID).
REQ-009 SHALL have port in_ready  out  1  upstream ready (arg_1_TREADY).
REQ-010 SHALL have port dp_shift  out  1  advance the line-buffer/stencil datapath one pixel.
REQ-011 SHALL have port out_valid  out  1  downstream valid (arg_0_TVALID).
REQ-012 SHALL have port out_ready  in  1  downstream ready (arg_0_TREADY).
REQ-013 SHALL have port out_last  out  1  last output pixel of the frame (arg_0_TLAST).
REQ-014 SHALL have port x_idx  out  W_BITS  column of the next pixel to be accepted.
REQ-015 SHALL have port y_idx  out  W_BITS  row of the next pixel to be accepted.
REQ-016 SHALL have port busy  out  1  high in RUN and DRAIN.
REQ-017 SHALL have port done  out  1  one-cycle pulse when a frame completes.
REQ-018 SHALL have port cfg_err  out  1  one-cycle pulse when a start is rejected.

Function
REQ-019 SHALL implement the states IDLE, RUN and DRAIN.
REQ-020 In IDLE, start with cfg_width>=K and cfg_height>=K SHALL latch the config, clear x_idx/y_idx and enter RUN next cycle.
REQ-021 In IDLE, start with cfg_width<K or cfg_height<K SHALL pulse cfg_err the next cycle and remain in IDLE.
REQ-022 start in RUN or DRAIN SHALL be ignored: no cfg_err and no config change.
REQ-023 in_ready SHALL equal (state==RUN) && (!out_valid || out_ready).
REQ-024 dp_shift SHALL equal in_valid && in_ready, combinationally, with zero latency.
REQ-025 On dp_shift, x_idx SHALL increment; when x_idx==width-1 it SHALL wrap to 0 and y_idx SHALL increment.
REQ-026 On dp_shift with x_idx>=K-1 and y_idx>=K-1, out_valid SHALL be set the next cycle.
REQ-027 out_valid SHALL hold until out_valid && out_ready, with no drop while stalled.
REQ-028 Total output count SHALL be (width-K+1)*(height-K+1).
REQ-029 out_last SHALL be set with the out_valid produced by pixel (width-1, height-1) and SHALL hold with out_valid.
REQ-030 Accepting pixel (width-1, height-1) SHALL move the block to DRAIN, with in_ready low from the next cycle.
REQ-031 In DRAIN, the handshake of the last output SHALL move the block to IDLE and pulse done in the same cycle.
REQ-032 A simultaneous out handshake and new dp_shift SHALL keep out_valid high, giving full throughput of 1 pixel/cycle.
REQ-033 Counter arithmetic SHALL be unsigned W_BITS, and compares SHALL use the latched config only.

Reset
REQ-034 rst SHALL asynchronously force: state IDLE, and out_valid, out_last, done, cfg_err, x_idx, y_idx, latched config and in_ready all 0.
REQ-035 rst mid-frame SHALL discard the frame; the first cycle after release SHALL be IDLE, accepting start.

Configuration
REQ-036 With GB_FRAME_CTRL_PERF_EN defined, the block SHALL add outputs perf_stall_in[31:0] and perf_stall_out[31:0].
REQ-037 perf_stall_in SHALL count RUN cycles with in_ready && !in_valid.
REQ-038 perf_stall_out SHALL count cycles with out_valid && !out_ready.
REQ-039 Both perf counters SHALL clear on an accepted start and on rst, and SHALL saturate at all-ones.
REQ-040 Without GB_FRAME_CTRL_PERF_EN, the perf ports and their logic SHALL be absent.

Structure
REQ-041 A shared package gb_pkg SHALL hold the state enum (IDLE/RUN/DRAIN) and the default constants K=9 and W_BITS=10, for reuse by the ILA/HLS equivalence wrappers.
REQ-042 The output valid/last holding register SHALL be a sub-module gb_out_reg (a 1-entry register with valid/ready).
REQ-043 The counters and the FSM SHALL stay in the top module.

Verification
REQ-044 Bench SHALL cover: 9x9 frame, in_valid=1, out_ready=1 -> exactly 1 output, out_last=1 on it, done 1 cycle after the 81st accept.
REQ-045 Bench SHALL cover: 12x10 frame at full rate -> 8 outputs, first out_valid the cycle after pixel (8,8), 1 pixel/cycle, then done.
REQ-046 Bench SHALL cover: out_ready=0 for 5 cycles mid-frame -> in_ready=0, dp_shift=0, out_valid held, no output lost and none duplicated.
REQ-047 Bench SHALL cover: start with cfg_width=8 -> cfg_err pulse, busy stays 0; start during RUN -> ignored.
REQ-048 Bench SHALL cover: rst asserted at pixel 40 of a 9x9 frame -> all outputs 0 immediately, then a new start runs a clean frame.
REQ-049 With PERF_EN, the bench SHALL cover: 3 idle in_valid cycles and 4 blocked out_ready cycles -> perf_stall_in=3 and perf_stall_out=4 at done.
